data_router: RTL and testbench
==============================

DATA_ROUTER -- requirements
Module: data_router

Interface
REQ-001 SHALL have ports: clk  in  1  clock, rising-edge.
REQ-002 SHALL have ports: nrst  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: in_byte  in  8  byte from reader, valid only when in_pulse=1.
REQ-004 SHALL have ports: in_is_key  in  1  1=key byte, 0=data byte; qualified by in_pulse.
REQ-005 SHALL have ports: in_pulse  in  1  single-cycle byte strobe from reader.
REQ-006 SHALL have ports: clear_pulse  in  1  single-cycle flush (driven by hash-reset pulse).
REQ-007 SHALL have ports: key  out  64  assembled key, first byte received in bits [63:56].
REQ-008 SHALL have ports: key_valid  out  1  level, 8 key bytes assembled.
REQ-009 SHALL have ports: key_update  out  1  one-cycle pulse when key_valid rises.
REQ-010 SHALL have ports: data_out  out  8  FIFO head byte.
REQ-011 SHALL have ports: data_valid  out  1  FIFO non-empty.
REQ-012 SHALL have ports: data_ready  in  1  consumer pops head when data_valid&&data_ready.
REQ-013 SHALL have ports: fifo_count  out  3  occupancy 0..4.
REQ-014 SHALL have ports: overflow_err  out  1  sticky, data byte dropped on full.
REQ-015 SHALL have ports: nokey_err  out  1  sticky, data byte dropped while key_valid=0.

Function
REQ-016 Key path: on in_pulse&&in_is_key, key SHALL shift left 8 with in_byte entering [7:0]; key_cnt (0..7) increments.
REQ-017 On the 8th key byte, key_valid SHALL be 1 and key_update 1 for exactly one cycle, both from the next edge; key_cnt returns to 0.
REQ-018 A key byte arriving while key_valid=1 SHALL drop key_valid to 0, set key = {56'b0, in_byte}, key_cnt=1 (new key accumulation; no key_update).
REQ-019 Data path: 4-entry first-word-fall-through FIFO; in_pulse&&!in_is_key&&key_valid pushes in_byte.
REQ-020 Push-to-data_valid latency SHALL be 1 cycle; no same-cycle bypass when empty.
REQ-021 Pop SHALL occur when data_valid&&data_ready; data_out SHALL show next entry the following cycle.
REQ-022 Push while full and no pop: byte dropped, overflow_err set.
REQ-023 Push while full with simultaneous pop: push accepted, count stays 4.
REQ-024 Push and pop when 0<count<4: count unchanged, order preserved.
REQ-025 Data byte while key_valid=0: byte dropped, nokey_err set, FIFO unchanged.
REQ-026 Pointers SHALL be 2-bit and wrap modulo 4; fifo_count SHALL equal pushes minus pops.
REQ-027 clear_pulse SHALL, on the next edge, empty FIFO, clear key to 0, key_cnt, key_valid, key_update, both error flags.
REQ-028 clear_pulse concurrent with in_pulse or pop: clear wins; byte discarded; no error flag set.
REQ-029 data_out SHALL be 0 when FIFO empty.

Reset
REQ-030 On nrst=0 asynchronously: key=0, key_valid=0, key_update=0, FIFO empty, data_out=0, data_valid=0, fifo_count=0, both errs=0, key_cnt=0.
REQ-031 Reset mid-key-assembly or mid-drain SHALL discard all partial state; first edge after release operates normally.

Configuration
REQ-032 Macro DATA_ROUTER_ERR_FLAGS_EN defined: overflow_err and nokey_err behave per REQ-022/025/027.
REQ-033 Macro undefined: overflow_err and nokey_err SHALL be constant 0; dropping behaviour unchanged; ports retained.

Verification
REQ-034 Key bytes 01..08 -> key=0x0102030405060708, key_valid=1, key_update one cycle after 8th pulse.
REQ-035 Key loaded, data A0,A1,A2,A3,A4 with data_ready=0 -> count=4, A4 dropped, overflow_err=1, pops return A0..A3.
REQ-036 Count=4, data_ready=1 with push B0 same cycle -> count stays 4, B0 emerges last.
REQ-037 No key, data 55 -> data_valid stays 0, nokey_err=1.
REQ-038 Key loaded, 2 bytes queued, clear_pulse with simultaneous data pulse -> count=0, key_valid=0, errs=0.
REQ-039 Seven key bytes then nrst pulse then 8 key bytes 11..18 -> key=0x1112131415161718, single key_update.

Source files
------------

// File: rtl/data_router_if.sv
// data_router_if: byte-stream, key and FIFO signals between the reader, the router and the consumer
interface data_router_if;
  logic [7:0]  in_byte;
  logic        in_is_key;
  logic        in_pulse;
  logic        clear_pulse;
  logic [63:0] key;
  logic        key_valid;
  logic        key_update;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        data_ready;
  logic [2:0]  fifo_count;
  logic        overflow_err;
  logic        nokey_err;
  modport master (
    output in_byte, in_is_key, in_pulse, clear_pulse, data_ready,
    input  key, key_valid, key_update, data_out, data_valid, fifo_count, overflow_err, nokey_err
  );
  modport slave (
    input  in_byte, in_is_key, in_pulse, clear_pulse, data_ready,
    output key, key_valid, key_update, data_out, data_valid, fifo_count, overflow_err, nokey_err
  );
endinterface

// File: rtl/data_router.sv
// data_router: assembles 8-byte keys and queues data bytes in a 4-deep FWFT FIFO
// sticky error flags are live only when DATA_ROUTER_ERR_FLAGS_EN is defined
module data_router (
  input logic clk,
  input logic nrst,
  data_router_if.slave bus
);
  logic [63:0] key;
  logic [2:0]  key_cnt;
  logic        key_valid, key_update;
  logic [7:0]  mem [4];
  logic [1:0]  wr_ptr, rd_ptr;
  logic [2:0]  count;
  logic        key_in, data_in, pop, push;
  assign key_in  = bus.in_pulse && bus.in_is_key;
  assign data_in = bus.in_pulse && !bus.in_is_key;
  assign pop     = (count != 3'd0) && bus.data_ready && !bus.clear_pulse;
  assign push    = data_in && key_valid && !bus.clear_pulse && (count != 3'd4 || pop);
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      key        <= 64'h0;
      key_cnt    <= 3'd0;
      key_valid  <= 1'b0;
      key_update <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
    end else if (bus.clear_pulse) begin
      key        <= 64'h0;
      key_cnt    <= 3'd0;
      key_valid  <= 1'b0;
      key_update <= 1'b0;
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
    end else begin
      key_update <= 1'b0;
      if (key_in && key_valid) begin
        key       <= {56'h0, bus.in_byte};
        key_valid <= 1'b0;
        key_cnt   <= 3'd1;
      end else if (key_in) begin
        key     <= {key[55:0], bus.in_byte};
        key_cnt <= key_cnt + 3'd1;
        if (key_cnt == 3'd7) begin
          key_valid  <= 1'b1;
          key_update <= 1'b1;
        end
      end
      if (push) wr_ptr <= wr_ptr + 2'd1;
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b0, push} - {2'b0, pop};
    end
  // storage needs no reset: data_out is gated by occupancy
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.in_byte;
  assign bus.key        = key;
  assign bus.key_valid  = key_valid;
  assign bus.key_update = key_update;
  assign bus.data_valid = count != 3'd0;
  assign bus.data_out   = (count != 3'd0) ? mem[rd_ptr] : 8'h00;
  assign bus.fifo_count = count;
`ifdef DATA_ROUTER_ERR_FLAGS_EN
  logic ovf, nokey;
  always_ff @(posedge clk or negedge nrst)
    if (!nrst) begin
      ovf   <= 1'b0;
      nokey <= 1'b0;
    end else if (bus.clear_pulse) begin
      ovf   <= 1'b0;
      nokey <= 1'b0;
    end else begin
      if (data_in && key_valid && count == 3'd4 && !pop) ovf <= 1'b1;
      if (data_in && !key_valid) nokey <= 1'b1;
    end
  assign bus.overflow_err = ovf;
  assign bus.nokey_err    = nokey;
`else
  assign bus.overflow_err = 1'b0;
  assign bus.nokey_err    = 1'b0;
`endif
endmodule

// File: tb/tb_data_router.sv
// tb_data_router: directed and random stimulus checked every cycle against a queue-based model
module tb_data_router;
`ifdef DATA_ROUTER_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic nrst = 1'b0;
  int checks = 0;
  int errors = 0;
  int n_upd = 0;
  data_router_if bus();
  data_router dut (.clk(clk), .nrst(nrst), .bus(bus));
  always #5 clk = ~clk;
  logic [7:0] q[$];
  logic [7:0] kq[$];
  bit m_valid = 0, m_upd = 0, m_ovf = 0, m_nokey = 0;
  function automatic logic [63:0] mkey();
    logic [63:0] k = 64'h0;
    foreach (kq[i]) k = {k[55:0], kq[i]};
    return k;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask
  // reference: the FIFO is a queue, the key is the byte list folded together
  always @(posedge clk or negedge nrst) begin
    bit pp, ps;
    pp = 0;
    ps = 0;
    m_upd = 0;
    if (!nrst || bus.clear_pulse) begin
      q.delete();
      kq.delete();
      m_valid = 0;
      m_ovf = 0;
      m_nokey = 0;
    end else begin
      pp = q.size() > 0 && bus.data_ready;
      if (bus.in_pulse && bus.in_is_key) begin
        if (m_valid) begin
          kq.delete();
          m_valid = 0;
        end
        kq.push_back(bus.in_byte);
        if (kq.size() == 8) begin
          m_valid = 1;
          m_upd = 1;
        end
      end else if (bus.in_pulse) begin
        if (!m_valid) m_nokey = 1;
        else if (q.size() == 4 && !pp) m_ovf = 1;
        else ps = 1;
      end
      if (pp) void'(q.pop_front());
      if (ps) q.push_back(bus.in_byte);
    end
  end
  always @(negedge clk) begin
    check("key", bus.key, mkey());
    check("key_valid", bus.key_valid, m_valid);
    check("key_update", bus.key_update, m_upd);
    check("data_valid", bus.data_valid, q.size() > 0);
    check("data_out", bus.data_out, q.size() > 0 ? q[0] : 8'h00);
    check("fifo_count", bus.fifo_count, q.size());
    check("overflow_err", bus.overflow_err, ERR_EN && m_ovf);
    check("nokey_err", bus.nokey_err, ERR_EN && m_nokey);
    if (bus.key_update) n_upd++;
  end
  task automatic step(input bit p, input bit k, input logic [7:0] b, input bit c, input bit r);
    bus.in_pulse = p;
    bus.in_is_key = k;
    bus.in_byte = b;
    bus.clear_pulse = c;
    bus.data_ready = r;
    @(posedge clk);
    #1;
    bus.in_pulse = 0;
    bus.clear_pulse = 0;
  endtask
  task automatic load_key(input logic [7:0] base);
    for (int i = 0; i < 8; i++) step(1, 1, base + 8'(i), 0, 0);
  endtask
  initial begin
    logic [7:0] exp_seq [4];
    int n0;
    bus.in_pulse = 0;
    bus.in_is_key = 0;
    bus.in_byte = 0;
    bus.clear_pulse = 0;
    bus.data_ready = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_count", bus.fifo_count, 0);
    check("rst_key", bus.key, 0);
    check("rst_valid", bus.data_valid, 0);
    nrst = 1;
    step(0, 0, 0, 0, 0);
    load_key(8'h01);
    check("key_literal", bus.key, 64'h0102030405060708);
    check("key_valid_lit", bus.key_valid, 1);
    check("key_update_lit", bus.key_update, 1);
    step(0, 0, 0, 0, 0);
    check("key_update_drop", bus.key_update, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 8'hA0 + 8'(i), 0, 0);
    check("full_count", bus.fifo_count, 4);
    check("ovf_lit", bus.overflow_err, ERR_EN);
    for (int i = 0; i < 4; i++) begin
      check("pop_order", bus.data_out, 8'hA0 + 8'(i));
      step(0, 0, 0, 0, 1);
    end
    check("drained", bus.fifo_count, 0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'hC0 + 8'(i), 0, 0);
    step(1, 0, 8'hB0, 0, 1);
    check("full_pushpop", bus.fifo_count, 4);
    exp_seq = '{8'hC1, 8'hC2, 8'hC3, 8'hB0};
    for (int i = 0; i < 4; i++) begin
      check("b0_last", bus.data_out, exp_seq[i]);
      step(0, 0, 0, 0, 1);
    end
    step(0, 0, 0, 1, 0);
    step(1, 0, 8'h55, 0, 0);
    check("nokey_valid", bus.data_valid, 0);
    check("nokey_lit", bus.nokey_err, ERR_EN);
    load_key(8'h21);
    step(1, 0, 8'h01, 0, 0);
    step(1, 0, 8'h02, 0, 0);
    step(1, 0, 8'h03, 1, 1);
    check("clr_count", bus.fifo_count, 0);
    check("clr_kv", bus.key_valid, 0);
    check("clr_ovf", bus.overflow_err, 0);
    check("clr_nokey", bus.nokey_err, 0);
    for (int i = 0; i < 7; i++) step(1, 1, 8'h70 + 8'(i), 0, 0);
    nrst = 0;
    #2 nrst = 1;
    n0 = n_upd;
    load_key(8'h11);
    step(0, 0, 0, 0, 0);
    check("key_after_rst", bus.key, 64'h1112131415161718);
    check("single_update", n_upd - n0, 1);
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 1), $urandom_range(0, 4) == 0, 8'($urandom), $urandom_range(0, 63) == 0,
           $urandom_range(0, 2) != 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
